conversor_bcd: RTL

// - Sequential binary-to-BCD converter (shift-and-add-3) for the vending-machine display path.
// - Takes a binary amount (credit/price) plus a start pulse and returns DIGITS packed BCD digits.
// - Also returns a leading-zero blank mask.
// - Sits directly upstream of the 4-display scan multiplexer: digit i drives display position i (i=0 is units).

---
 rtl/conversor_bcd_pkg.sv | 18 +
 rtl/ajuste_bcd.sv | 12 +
 rtl/conversor_bcd.sv | 114 +++++++++++
 3 files changed

// File: rtl/conversor_bcd_pkg.sv
// Shared definitions for the binary-to-BCD display converter:
// FSM encoding, default sizes and the add-3 nibble constants.
package conversor_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIM   = 2'd2
  } estado_t;

  localparam int DEFAULT_WIDTH  = 14;
  localparam int DEFAULT_DIGITS = 4;
  localparam int NIBBLE_W       = 4;

  localparam logic [NIBBLE_W-1:0] LIMIAR_AJUSTE = 4'd5;
  localparam logic [NIBBLE_W-1:0] SOMA_AJUSTE   = 4'd3;

endpackage

// File: rtl/ajuste_bcd.sv
// Combinational nibble correction for shift-and-add-3: any nibble >= 5
// gets +3 so that the following left shift carries into the next decade.
module ajuste_bcd
  import conversor_bcd_pkg::*;
(
  input  logic [NIBBLE_W-1:0] entrada,
  output logic [NIBBLE_W-1:0] saida
);

  assign saida = (entrada >= LIMIAR_AJUSTE) ? entrada + SOMA_AJUSTE : entrada;

endmodule

// File: rtl/conversor_bcd.sv
// Sequential binary-to-BCD converter feeding the display scan multiplexer.
// One bit is shifted per clock; results, blank mask and overflow are held until the next conversion.
module conversor_bcd
  import conversor_bcd_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           valor,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [NIBBLE_W*DIGITS-1:0] digitos,
  output logic [DIGITS-1:0]          apagar,
  output logic                       overflow
);

  localparam int BCDW = NIBBLE_W * DIGITS;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [63:0]     MAXV  = 64'(10 ** DIGITS - 1);
  localparam logic [BCDW-1:0] NOVES = {DIGITS{4'd9}};

  estado_t           state, state_next;
  logic [WIDTH-1:0]  shift;
  logic [BCDW-1:0]   bcd, bcd_adj, resultado;
  logic [CW-1:0]     cnt;
  logic              sat;
  logic [DIGITS-1:0] mascara;
  logic              zeros;
  logic              carregar, deslocar, finalizar;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    carregar   = 1'b0;
    deslocar   = 1'b0;
    finalizar  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          carregar   = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        deslocar = 1'b1;
        if (cnt == CW'(1)) state_next = FIM;
      end
      FIM: begin
        finalizar  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  for (genvar g = 0; g < DIGITS; g++) begin : g_ajuste
    ajuste_bcd u_ajuste (
      .entrada(bcd[NIBBLE_W*g +: NIBBLE_W]),
      .saida  (bcd_adj[NIBBLE_W*g +: NIBBLE_W])
    );
  end

  // Out-of-range inputs are replaced by all nines; the flag was latched at capture.
  assign resultado = sat ? NOVES : bcd;

  always_comb begin
    mascara = '0;
    zeros   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zeros      = zeros & (resultado[NIBBLE_W*i +: NIBBLE_W] == 4'd0);
      mascara[i] = zeros;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift    <= '0;
      bcd      <= '0;
      cnt      <= '0;
      sat      <= 1'b0;
      done     <= 1'b0;
      digitos  <= '0;
      apagar   <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (carregar) begin
        shift <= valor;
        bcd   <= '0;
        cnt   <= CW'(WIDTH);
        sat   <= (64'(valor) > MAXV);
      end else if (deslocar) begin
        bcd   <= {bcd_adj[BCDW-2:0], shift[WIDTH-1]};
        shift <= shift << 1;
        cnt   <= cnt - CW'(1);
      end else if (finalizar) begin
        digitos  <= resultado;
        apagar   <= mascara;
        overflow <= sat;
        done     <= 1'b1;
      end
    end
  end

endmodule
